// File: rtl/debug_io_ctrl.sv
// debug_io_ctrl
// Debug-port access sequencer sitting directly upstream of the CPU state mux.
// It takes one host command at a time, borrows the addressed resource
// (icache, dcache or regfile port 2) from the CPU for a short access window,
// and hands the read data back on a valid/ready response channel.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   cmd_valid/ready   host command handshake (ready only while idle)
//   cmd_op            1=ICRD 2=ICWR 3=DCRD 4=REGRD, anything else is illegal
//   cmd_addr          target address, truncated to the selected resource
//   cmd_wdata         icache write data (ICWR only)
//   rsp_valid/ready   response handshake
//   rsp_data          read data (0 for writes and illegal ops)
//   rsp_err           set for an illegal op
//   debug             mode code to the mux, 0 = CPU owns everything
//   ext_icache_*      icache control (active-low ceb/web)
//   ext_dcache_*      dcache control (read-only: web and bweb stay inactive)
//   ext_reg_*         regfile port-2 read strobe and address
//   icache_dout, dcache_dout, reg_rdata2
//                     resource read data, valid one cycle after the strobe
module debug_io_ctrl #(
    parameter int DEBUG_WIDTH = 3,
    parameter int CMD_AW      = 16,
    parameter int IADDR_WIDTH = 10,
    parameter int DADDR_WIDTH = 10,
    parameter int RADDR_WIDTH = 5,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [DEBUG_WIDTH-1:0] cmd_op,
    input  logic [CMD_AW-1:0]      cmd_addr,
    input  logic [DATA_WIDTH-1:0]  cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic                   rsp_err,
    output logic [DEBUG_WIDTH-1:0] debug,
    output logic                   ext_icache_ceb,
    output logic                   ext_icache_web,
    output logic [IADDR_WIDTH-1:0] ext_icache_addr,
    output logic [DATA_WIDTH-1:0]  ext_icache_din,
    output logic                   ext_dcache_ceb,
    output logic                   ext_dcache_web,
    output logic [DATA_WIDTH-1:0]  ext_dcache_bweb,
    output logic [DADDR_WIDTH-1:0] ext_dcache_addr,
    output logic                   ext_reg_read2,
    output logic [RADDR_WIDTH-1:0] ext_reg_rs2,
    input  logic [DATA_WIDTH-1:0]  icache_dout,
    input  logic [DATA_WIDTH-1:0]  dcache_dout,
    input  logic [DATA_WIDTH-1:0]  reg_rdata2
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [DEBUG_WIDTH-1:0] OP_ICRD  = DEBUG_WIDTH'(1);
    localparam logic [DEBUG_WIDTH-1:0] OP_ICWR  = DEBUG_WIDTH'(2);
    localparam logic [DEBUG_WIDTH-1:0] OP_DCRD  = DEBUG_WIDTH'(3);
    localparam logic [DEBUG_WIDTH-1:0] OP_REGRD = DEBUG_WIDTH'(4);

    logic [1:0]             r_state;
    logic [DEBUG_WIDTH-1:0] r_op;
    logic [IADDR_WIDTH-1:0] r_iaddr;
    logic [DADDR_WIDTH-1:0] r_daddr;
    logic [RADDR_WIDTH-1:0] r_raddr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [DATA_WIDTH-1:0]  r_rspData;
    logic                   r_rspErr;

    logic w_accept;
    logic w_legal;
    logic w_inAccess;
    logic w_opIcache;

    assign w_accept   = cmd_valid && (r_state == S_IDLE);
    assign w_legal    = (cmd_op == OP_ICRD) || (cmd_op == OP_ICWR) ||
                        (cmd_op == OP_DCRD) || (cmd_op == OP_REGRD);
    assign w_inAccess = (r_state == S_ACCESS);
    assign w_opIcache = (r_op == OP_ICRD) || (r_op == OP_ICWR);

    // Sequencer. Each target only latches its own address so the address
    // buses of resources that are not being accessed stay quiet. An illegal
    // op never touches a resource and goes straight to the response state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_iaddr   <= '0;
            r_daddr   <= '0;
            r_raddr   <= '0;
            r_wdata   <= '0;
            r_rspData <= '0;
            r_rspErr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= cmd_op;
                        r_rspData <= '0;
                        if (w_legal) begin
                            r_rspErr <= 1'b0;
                            r_state  <= S_ACCESS;
                            if ((cmd_op == OP_ICRD) || (cmd_op == OP_ICWR)) begin
                                r_iaddr <= cmd_addr[IADDR_WIDTH-1:0];
                            end
                            if (cmd_op == OP_ICWR) begin
                                r_wdata <= cmd_wdata;
                            end
                            if (cmd_op == OP_DCRD) begin
                                r_daddr <= cmd_addr[DADDR_WIDTH-1:0];
                            end
                            if (cmd_op == OP_REGRD) begin
                                r_raddr <= cmd_addr[RADDR_WIDTH-1:0];
                            end
                        end else begin
                            r_rspErr <= 1'b1;
                            r_state  <= S_RESP;
                        end
                    end
                end
                S_ACCESS: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // Resource data is valid this cycle; a write has no
                    // read data so rsp_data keeps the 0 set on accept.
                    case (r_op)
                        OP_ICRD:  r_rspData <= icache_dout;
                        OP_DCRD:  r_rspData <= dcache_dout;
                        OP_REGRD: r_rspData <= reg_rdata2;
                        default:  r_rspData <= '0;
                    endcase
                    r_state <= S_RESP;
                end
                default: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Strobes are decoded from the state so they are active for exactly the
    // single ACCESS cycle and only for the resource the latched op selects.
    assign cmd_ready       = (r_state == S_IDLE);
    assign debug           = ((r_state == S_ACCESS) || (r_state == S_CAPTURE)) ? r_op : '0;
    assign ext_icache_ceb  = !(w_inAccess && w_opIcache);
    assign ext_icache_web  = !(w_inAccess && (r_op == OP_ICWR));
    assign ext_icache_addr = r_iaddr;
    assign ext_icache_din  = r_wdata;
    assign ext_dcache_ceb  = !(w_inAccess && (r_op == OP_DCRD));
    assign ext_dcache_web  = 1'b1;
    assign ext_dcache_bweb = '1;
    assign ext_dcache_addr = r_daddr;
    assign ext_reg_read2   = w_inAccess && (r_op == OP_REGRD);
    assign ext_reg_rs2     = r_raddr;
    assign rsp_valid       = (r_state == S_RESP);
    assign rsp_data        = r_rspData;
    assign rsp_err         = r_rspErr;

endmodule

// File: tb/tb_debug_io_ctrl.sv
// tb_debug_io_ctrl
// Bench for debug_io_ctrl. Models the icache, dcache and regfile as simple
// synchronous memories driven by the DUT strobes, and keeps a separate
// reference copy of their contents that is updated from the command stream
// alone. Expected responses go into a queue that an independent monitor
// drains whenever a response handshake is about to happen.
module tb_debug_io_ctrl;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [2:0]  debug;
    logic        ext_icache_ceb;
    logic        ext_icache_web;
    logic [9:0]  ext_icache_addr;
    logic [31:0] ext_icache_din;
    logic        ext_dcache_ceb;
    logic        ext_dcache_web;
    logic [31:0] ext_dcache_bweb;
    logic [9:0]  ext_dcache_addr;
    logic        ext_reg_read2;
    logic [4:0]  ext_reg_rs2;
    logic [31:0] icache_dout;
    logic [31:0] dcache_dout;
    logic [31:0] reg_rdata2;

    logic [31:0] envIc  [0:1023];
    logic [31:0] envDc  [0:1023];
    logic [31:0] envReg [0:31];
    logic [31:0] refIc  [0:1023];
    logic [31:0] refDc  [0:1023];
    logic [31:0] refReg [0:31];

    exp_t sbQ[$];
    int   nChecks;
    int   nFails;

    debug_io_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .debug           (debug),
        .ext_icache_ceb  (ext_icache_ceb),
        .ext_icache_web  (ext_icache_web),
        .ext_icache_addr (ext_icache_addr),
        .ext_icache_din  (ext_icache_din),
        .ext_dcache_ceb  (ext_dcache_ceb),
        .ext_dcache_web  (ext_dcache_web),
        .ext_dcache_bweb (ext_dcache_bweb),
        .ext_dcache_addr (ext_dcache_addr),
        .ext_reg_read2   (ext_reg_read2),
        .ext_reg_rs2     (ext_reg_rs2),
        .icache_dout     (icache_dout),
        .dcache_dout     (dcache_dout),
        .reg_rdata2      (reg_rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Resource models: data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (!ext_icache_ceb) begin
            if (!ext_icache_web) envIc[ext_icache_addr] <= ext_icache_din;
            icache_dout <= envIc[ext_icache_addr];
        end
        if (!ext_dcache_ceb) dcache_dout <= envDc[ext_dcache_addr];
        if (ext_reg_read2)   reg_rdata2  <= envReg[ext_reg_rs2];
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (sbQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected_rsp: got data 0x%0h err %0b, expected no response", rsp_data, rsp_err);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("rsp_data", rsp_data, e.data);
                    checkOutput("rsp_err", rsp_err, e.err);
                end
            end
        end
    end

    task automatic checkIdleStrobes(input string tag);
        checkOutput({tag, "_ic_ceb"}, ext_icache_ceb, 1);
        checkOutput({tag, "_ic_web"}, ext_icache_web, 1);
        checkOutput({tag, "_dc_ceb"}, ext_dcache_ceb, 1);
        checkOutput({tag, "_dc_web"}, ext_dcache_web, 1);
        checkOutput({tag, "_read2"}, ext_reg_read2, 0);
    endtask

    // Issues one command, checks the access window and latency, then
    // completes the response handshake after 'hold' cycles of backpressure
    // (hold==0 means rsp_ready is already high when the response appears).
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] addr,
                                 input logic [31:0] wdata, input int hold);
        exp_t        e;
        logic        legal;
        logic [9:0]  ia;
        logic [9:0]  da;
        logic [4:0]  ra;
        int          n;
        int          lat;
        legal = (op >= 3'd1) && (op <= 3'd4);
        ia = addr[9:0];
        da = addr[9:0];
        ra = addr[4:0];
        e.data = 32'h0;
        e.err  = 1'b0;
        case (op)
            3'd1: e.data = refIc[ia];
            3'd2: refIc[ia] = wdata;
            3'd3: e.data = refDc[da];
            3'd4: e.data = refReg[ra];
            default: e.err = 1'b1;
        endcase
        sbQ.push_back(e);
        rsp_ready = (hold == 0);

        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);

        if (legal) begin
            checkOutput("acc_debug", debug, op);
            checkOutput("acc_ic_ceb", ext_icache_ceb, !(op == 3'd1 || op == 3'd2));
            checkOutput("acc_ic_web", ext_icache_web, !(op == 3'd2));
            checkOutput("acc_dc_ceb", ext_dcache_ceb, !(op == 3'd3));
            checkOutput("acc_dc_web", ext_dcache_web, 1);
            checkOutput("acc_dc_bweb", ext_dcache_bweb, 32'hFFFFFFFF);
            checkOutput("acc_read2", ext_reg_read2, op == 3'd4);
            if (op == 3'd1 || op == 3'd2) checkOutput("acc_ic_addr", ext_icache_addr, ia);
            if (op == 3'd2) checkOutput("acc_ic_din", ext_icache_din, wdata);
            if (op == 3'd3) checkOutput("acc_dc_addr", ext_dcache_addr, da);
            if (op == 3'd4) checkOutput("acc_rs2", ext_reg_rs2, ra);
        end else begin
            checkIdleStrobes("ill");
            checkOutput("ill_debug", debug, 0);
        end

        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (legal && lat == 2) begin
                checkIdleStrobes("cap");
                checkOutput("cap_debug", debug, op);
            end
        end
        checkOutput("latency", lat, legal ? 3 : 1);
        checkOutput("rsp_debug", debug, 0);

        for (int i = 0; i < hold; i++) begin
            checkOutput("hold_valid", rsp_valid, 1);
            checkOutput("hold_data", rsp_data, e.data);
            checkOutput("hold_err", rsp_err, e.err);
            @(negedge clk);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1 rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("post_valid", rsp_valid, 0);
        checkOutput("post_ready", cmd_ready, 1);
    endtask

    // Starts a dcache read and hits reset while it is in its access cycle.
    task automatic resetDuringAccess(input logic [15:0] addr);
        @(negedge clk);
        checkOutput("rst_pre_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        cmd_addr  = addr;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("rst_acc_dc_ceb", ext_dcache_ceb, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkIdleStrobes("rst");
        checkOutput("rst_debug", debug, 0);
        checkOutput("rst_valid", rsp_valid, 0);
        checkOutput("rst_ready", cmd_ready, 1);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        nChecks   = 0;
        nFails    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_addr  = 16'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            envIc[i] = v;
            refIc[i] = v;
            v = $urandom;
            envDc[i] = v;
            refDc[i] = v;
        end
        for (int i = 0; i < 32; i++) begin
            v = $urandom;
            envReg[i] = v;
            refReg[i] = v;
        end
        envDc[15] = 32'h12345678;
        refDc[15] = 32'h12345678;
        envReg[5] = 32'h55;
        refReg[5] = 32'h55;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        checkIdleStrobes("reset");
        checkOutput("reset_debug", debug, 0);
        checkOutput("reset_bweb", ext_dcache_bweb, 32'hFFFFFFFF);
        checkOutput("reset_cmd_ready", cmd_ready, 1);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        checkOutput("reset_rsp_data", rsp_data, 0);
        checkOutput("reset_ic_addr", ext_icache_addr, 0);
        checkOutput("reset_ic_din", ext_icache_din, 0);
        checkOutput("reset_dc_addr", ext_dcache_addr, 0);
        checkOutput("reset_rs2", ext_reg_rs2, 0);

        $display("[TB] directed commands");
        applyStimulus(3'd2, 16'h0003, 32'hDEADBEEF, 0);
        applyStimulus(3'd1, 16'h0003, 32'h0, 0);
        applyStimulus(3'd3, 16'h040F, 32'h0, 1);
        applyStimulus(3'd4, 16'h0005, 32'h0, 2);
        applyStimulus(3'd6, 16'h1234, 32'hFFFF, 0);
        applyStimulus(3'd0, 16'h0001, 32'h0, 1);
        applyStimulus(3'd1, 16'h0003, 32'h0, 4);
        resetDuringAccess(16'h000F);

        $display("[TB] random commands");
        for (int k = 0; k < 60; k++) begin
            applyStimulus(3'($urandom_range(0, 7)), 16'($urandom),
                          $urandom, $urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        checkOutput("sb_empty", sbQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
